edge_window_sequencer: RTL and testbench
========================================

// Module: edge_window_sequencer
// PURPOSE
//  Streams raster-order pixels into two line buffers and emits one 3x3 window per interior pixel.
//  Each window is a full neighbourhood for the gaussian / Sobel-H / Sobel-V kernel stage.
//  Sits between the pixel source and the kernel stage. Owns frame/row/column sequencing,
//  valid/ready flow control and end-of-row / end-of-frame marking.
// PARAMETERS
//  IMG_W  640  pixels per row (>=3)
//  IMG_H  480  rows per frame (>=3)
//  PIX_W  4    bits per pixel
// PORTS
//  clk        in   1          single clock, all logic rising-edge
//  rst_n      in   1          asynchronous assert, active-low reset
//  pix_in     in   PIX_W      input pixel
//  pix_valid  in   1          pix_in valid
//  pix_sof    in   1          qualifies pix_in as pixel (0,0) of a frame
//  pix_ready  out  1          block accepts pix_in this cycle
//  win        out  9*PIX_W    window; win[(r*3+c)*PIX_W +: PIX_W] = pixel[row-2+r][col-2+c]
//  win_valid  out  1          win/win_eol/win_eof valid
//  win_ready  in   1          kernel stage accepts window
//  win_eol    out  1          window is last of its row (col = IMG_W-1)
//  win_eof    out  1          window is last of frame (row = IMG_H-1, col = IMG_W-1)
//  frame_done out  1          1-cycle pulse after the eof window is consumed
//  sof_err    out  1          1-cycle pulse: pix_sof seen mid-frame
// BEHAVIOUR
//  Reset values:
//   - win, win_valid, win_eol, win_eof, frame_done, sof_err = 0.
//   - State IDLE; row/col counters = 0.
//  Line buffers are not reset. Their contents are don't-care until overwritten.
//  Handshakes:
//   - Pixel accept = pix_valid & pix_ready.
//   - Window transfer = win_valid & win_ready.
//   - pix_ready = (state != DONE) & (~win_valid | win_ready). Combinational.
//  FSM:
//   - IDLE:
//     - Accepted pixel with pix_sof=1 is pixel (0,0); go ACTIVE.
//     - Accepted pixel with pix_sof=0 is discarded, with no counter or buffer change.
//   - ACTIVE: each accepted pixel at (row,col) does the following:
//     - Shift the window columns left.
//     - Load a new right column {lb1[col], lb0[col], pix_in}.
//     - Write lb1[col] <= lb0[col] and lb0[col] <= pix_in.
//     - Advance col; wrap to 0 and increment row at IMG_W-1.
//     - The accept of (IMG_H-1, IMG_W-1) moves the FSM to DONE.
//   - DONE:
//     - pix_ready = 0.
//     - Stay until the eof window transfers, then pulse frame_done for 1 cycle and go IDLE.
//  Window output:
//   - An accept at row>=2 and col>=2 loads the output register.
//   - win_valid = 1 the next cycle (latency 1). eol/eof are set as defined.
//   - Border pixels (row<2 or col<2) produce no window.
//   - Output holds stable while win_valid & ~win_ready.
//   - win_valid clears on transfer unless a new window loads in the same cycle.
//   - Windows per frame = (IMG_H-2)*(IMG_W-2).
//  Boundary cases:
//   - pix_sof=1 accepted in ACTIVE, including at col 0: restart the frame.
//     - The pixel becomes (0,0) and sof_err pulses.
//     - A pending output window is still delivered, with eol/eof unchanged.
//   - pix_sof=1 on the last pixel of a frame: treated as a restart; no DONE and no frame_done.
//   - Column wrap: the window shift register is not cleared. Stale columns leave before col 2.
//   - rst_n low mid-frame: immediate return to reset values; any pending window is lost.
//  Counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide. No arithmetic on pixel values.
// TESTING (IMG_W=5, IMG_H=4, PIX_W=4 unless noted)
//  1. Ramp frame, pix(r,c) = r*5+c, sof on first pixel, win_ready=1:
//     - First window one cycle after the accept of (2,2), with values {0,1,2,5,6,7,10,11,12}.
//     - Exactly 6 windows; eol on windows 3 and 6; eof on window 6.
//     - frame_done pulses 1 cycle after window 6; Sobel-H output = 8 for every window.
//  2. Backpressure: hold win_ready=0 for 3 cycles after the first window.
//     - win stays at {0,1,2,5,6,7,10,11,12}; pix_ready = 0.
//     - No pixels are lost; the full 6-window sequence is still produced.
//  3. IDLE garbage: 7 pixels with pix_sof=0, then the ramp frame.
//     - Garbage is discarded and pix_ready=1 throughout.
//     - Output is identical to test 1.
//  4. Restart: pix_sof=1 at pixel (2,3) of the ramp, then a full frame.
//     - sof_err pulses once; the restart pixel is counted as (0,0).
//     - The next 6 windows come from the new frame only.
//  5. Reset mid-frame: rst_n=0 for 2 cycles after window 2.
//     - All outputs go to 0 asynchronously.
//     - A new frame then yields the full 6-window sequence.
//  6. Random valid/ready toggling over 3 back-to-back frames, compared against a reference model:
//     - 18 windows and 3 frame_done pulses; no window duplicated or dropped.

Source files
------------

// File: rtl/edge_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : edge_window_sequencer
// Function : Raster pixels -> two line buffers -> one 3x3 window per interior
//            pixel, with valid/ready flow control and row/frame marking.
// Revision : 1.0  initial release
// ============================================================================
module edge_window_sequencer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               pix_sof,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] win,
    output logic               win_valid,
    input  logic               win_ready,
    output logic               win_eol,
    output logic               win_eof,
    output logic               frame_done,
    output logic               sof_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] c_COL_TWO  = CW'(2);
    localparam logic [CW-1:0] c_COL_ONE  = CW'(1);
    localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] c_ROW_TWO  = RW'(2);
    localparam logic [RW-1:0] c_ROW_ONE  = RW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [9*PIX_W-1:0]   win_q, win_d;
    logic                 win_valid_q, win_valid_d;
    logic                 win_eol_q, win_eol_d;
    logic                 win_eof_q, win_eof_d;
    logic                 frame_done_q, frame_done_d;
    logic                 sof_err_q, sof_err_d;

    // Columns 1 and 2 of the most recent window, indexed r*2+c.
    logic [6*PIX_W-1:0]   hist_q;
    logic [PIX_W-1:0]     lb0_q [IMG_W];
    logic [PIX_W-1:0]     lb1_q [IMG_W];

    logic                 w_pix_ready;
    logic                 w_acc;
    logic                 w_proc;
    logic                 w_xfer;
    logic [CW-1:0]        w_col;
    logic [RW-1:0]        w_row;
    logic                 w_col_last;
    logic                 w_row_last;
    logic                 w_win_load;
    logic [PIX_W-1:0]     w_new_col [3];
    logic [9*PIX_W-1:0]   w_next_win;
    logic [6*PIX_W-1:0]   w_hist_next;

    assign w_pix_ready = (state_q != S_DONE) & (~win_valid_q | win_ready);
    assign w_acc       = pix_valid & w_pix_ready;
    // In IDLE only a start-of-frame pixel is meaningful; everything else is dropped.
    assign w_proc      = w_acc & (pix_sof | (state_q == S_ACTIVE));
    assign w_xfer      = win_valid_q & win_ready;
    assign w_col       = pix_sof ? '0 : col_q;
    assign w_row       = pix_sof ? '0 : row_q;
    assign w_col_last  = (w_col == c_COL_LAST);
    assign w_row_last  = (w_row == c_ROW_LAST);
    assign w_win_load  = w_proc & (w_row >= c_ROW_TWO) & (w_col >= c_COL_TWO);

    always_comb begin
        w_new_col[0] = lb1_q[w_col];
        w_new_col[1] = lb0_q[w_col];
        w_new_col[2] = pix_in;
        w_next_win   = '0;
        w_hist_next  = '0;
        for (int r = 0; r < 3; r++) begin
            w_next_win[(r*3+0)*PIX_W +: PIX_W] = hist_q[(r*2+0)*PIX_W +: PIX_W];
            w_next_win[(r*3+1)*PIX_W +: PIX_W] = hist_q[(r*2+1)*PIX_W +: PIX_W];
            w_next_win[(r*3+2)*PIX_W +: PIX_W] = w_new_col[r];
            w_hist_next[(r*2+0)*PIX_W +: PIX_W] = hist_q[(r*2+1)*PIX_W +: PIX_W];
            w_hist_next[(r*2+1)*PIX_W +: PIX_W] = w_new_col[r];
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q & ~w_xfer;
        win_eol_d    = win_eol_q;
        win_eof_d    = win_eof_q;
        frame_done_d = 1'b0;
        sof_err_d    = w_acc & pix_sof & (state_q == S_ACTIVE);

        if (w_proc) begin
            state_d = S_ACTIVE;
            if (w_col_last) begin
                col_d = '0;
                if (w_row_last) begin
                    row_d   = '0;
                    state_d = S_DONE;
                end else begin
                    row_d = w_row + c_ROW_ONE;
                end
            end else begin
                col_d = w_col + c_COL_ONE;
                row_d = w_row;
            end
        end

        if (w_win_load) begin
            win_d       = w_next_win;
            win_valid_d = 1'b1;
            win_eol_d   = w_col_last;
            win_eof_d   = w_col_last & w_row_last;
        end

        if ((state_q == S_DONE) && w_xfer && win_eof_q) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            win_eol_q    <= 1'b0;
            win_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_eol_q    <= win_eol_d;
            win_eof_q    <= win_eof_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    // Data-path storage carries no reset; stale content is flushed before use.
    always_ff @(posedge clk) begin
        if (w_proc) begin
            hist_q       <= w_hist_next;
            lb1_q[w_col] <= lb0_q[w_col];
            lb0_q[w_col] <= pix_in;
        end
    end

    assign pix_ready  = w_pix_ready;
    assign win        = win_q;
    assign win_valid  = win_valid_q;
    assign win_eol    = win_eol_q;
    assign win_eof    = win_eof_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_window_sequencer
// Function : Directed + random self-checking bench for edge_window_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_edge_window_sequencer;

    localparam int W = 5;
    localparam int H = 4;
    localparam int P = 4;
    localparam logic [35:0] FIRST = {4'd12, 4'd11, 4'd10, 4'd7, 4'd6, 4'd5, 4'd2, 4'd1, 4'd0};

    typedef struct packed {
        logic [35:0] w;
        logic        eol;
        logic        eof;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [P-1:0]  pix_in;
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_ready;
    logic [9*P-1:0] win;
    logic          win_valid;
    logic          win_ready;
    logic          win_eol;
    logic          win_eof;
    logic          frame_done;
    logic          sof_err;

    edge_window_sequencer #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
        .win(win), .win_valid(win_valid), .win_ready(win_ready),
        .win_eol(win_eol), .win_eof(win_eof), .frame_done(frame_done), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    int         m_state;   // 0 idle, 1 active, 2 done
    int         m_row, m_col;
    logic [3:0] img [H][W];
    exp_t       q [$];
    bit         exp_fd, exp_se;

    int n_chk, n_fail;
    int n_win, n_eol, n_eof, n_fd, n_se;
    int s_win, s_eol, s_eof, s_fd, s_se;
    bit sobel_on, first_on, rnd_ready, bp_arm, last_acc;
    int bp_left;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [3:0] p, input logic sof);
        exp_t e;
        if (m_state == 0 && !sof) return;
        if (sof) begin
            if (m_state == 1) exp_se = 1'b1;
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = p;
        if (m_row >= 2 && m_col >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.w[(r*3+c)*4 +: 4] = img[m_row-2+r][m_col-2+c];
            e.eol = (m_col == W-1);
            e.eof = e.eol && (m_row == H-1);
            q.push_back(e);
        end
        if (m_col == W-1) begin
            m_col = 0;
            if (m_row == H-1) begin
                m_row   = 0;
                m_state = 2;
            end else begin
                m_row++;
                m_state = 1;
            end
        end else begin
            m_col++;
            m_state = 1;
        end
    endtask

    // One clock: drive ready, check outputs at negedge+1, update model, advance.
    task automatic cycle();
        bit ev, er;
        exp_t e;
        logic [3:0] s;
        if (bp_arm && q.size() > 0) begin
            bp_left = 3;
            bp_arm  = 1'b0;
        end
        if (rnd_ready) win_ready = 1'($urandom_range(0, 1));
        else           win_ready = (bp_left > 0) ? 1'b0 : 1'b1;
        ev = (q.size() > 0);
        er = (m_state != 2) && (!ev || win_ready);
        #1;
        chk("win_valid", win_valid, ev);
        chk("pix_ready", pix_ready, er);
        chk("frame_done", frame_done, exp_fd);
        chk("sof_err", sof_err, exp_se);
        if (frame_done === 1'b1) n_fd++;
        if (sof_err === 1'b1) n_se++;
        exp_fd = 1'b0;
        exp_se = 1'b0;
        if (bp_left > 0) begin
            chk("bp_hold_win", win, FIRST);
            bp_left--;
        end
        if (ev && win_ready) begin
            e = q.pop_front();
            chk("win", win, e.w);
            chk("win_eol", win_eol, e.eol);
            chk("win_eof", win_eof, e.eof);
            n_win++;
            if (win_eol === 1'b1) n_eol++;
            if (win_eof === 1'b1) n_eof++;
            if (first_on) begin
                chk("first_win", win, FIRST);
                first_on = 1'b0;
            end
            if (sobel_on) begin
                s = (win[11:8] - win[3:0]) + ((win[23:20] - win[15:12]) << 1) + (win[35:32] - win[27:24]);
                chk("sobel_h", s, 4'd8);
            end
            if (e.eof && m_state == 2) begin
                m_state = 0;
                exp_fd  = 1'b1;
            end
        end
        last_acc = pix_valid && er;
        if (last_acc) model_accept(pix_in, pix_sof);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_pixel(input logic [3:0] p, input logic sof, input bit rnd_valid);
        int tries = 0;
        do begin
            pix_in    = p;
            pix_sof   = sof;
            pix_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            tries++;
        end while (!last_acc && tries < 100);
        chk("pix_accept", last_acc, 1'b1);
        pix_valid = 1'b0;
    endtask

    task automatic send_seq(input int n, input int offset, input bit rnd_pix, input bit rnd_valid);
        logic [3:0] p;
        for (int i = 0; i < n; i++) begin
            p = rnd_pix ? 4'($urandom) : 4'(i + offset);
            send_pixel(p, (i == 0), rnd_valid);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        while ((m_state != 0 || q.size() != 0 || exp_fd) && t < 100) begin
            cycle();
            t++;
        end
        chk("drain_timeout", (m_state == 0 && q.size() == 0 && !exp_fd), 1'b1);
    endtask

    task automatic snap();
        s_win = n_win; s_eol = n_eol; s_eof = n_eof; s_fd = n_fd; s_se = n_se;
    endtask

    task automatic frame_check(input string tag, input int ew, input int eeol,
                               input int eeof, input int efd, input int ese);
        chk({tag, "_windows"}, n_win - s_win, ew);
        chk({tag, "_eol"}, n_eol - s_eol, eeol);
        chk({tag, "_eof"}, n_eof - s_eof, eeof);
        chk({tag, "_frame_done"}, n_fd - s_fd, efd);
        chk({tag, "_sof_err"}, n_se - s_se, ese);
    endtask

    initial begin
        rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0; win_ready = 1'b1;
        m_state = 0; m_row = 0; m_col = 0; exp_fd = 1'b0; exp_se = 1'b0;
        n_chk = 0; n_fail = 0; n_win = 0; n_eol = 0; n_eof = 0; n_fd = 0; n_se = 0;
        sobel_on = 1'b1; first_on = 1'b0; rnd_ready = 1'b0; bp_arm = 1'b0; bp_left = 0;
        last_acc = 1'b0;

        #2;
        chk("rst_win", win, 36'h0);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_win_eol", win_eol, 1'b0);
        chk("rst_win_eof", win_eof, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_sof_err", sof_err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ramp frame, ready always high
        snap(); first_on = 1'b1;
        send_seq(20, 0, 1'b0, 1'b0);
        wait_done();
        frame_check("t1", 6, 2, 1, 1, 0);

        // 2: backpressure on the first window
        snap(); bp_arm = 1'b1;
        send_seq(20, 0, 1'b0, 1'b0);
        wait_done();
        frame_check("t2", 6, 2, 1, 1, 0);

        // 3: garbage in IDLE, then ramp
        snap();
        for (int i = 0; i < 7; i++) send_pixel(4'(i + 3), 1'b0, 1'b0);
        chk("t3_garbage_no_win", n_win - s_win, 0);
        first_on = 1'b1;
        send_seq(20, 0, 1'b0, 1'b0);
        wait_done();
        frame_check("t3", 6, 2, 1, 1, 0);

        // 4: restart at pixel (2,3), then a new frame with offset values
        snap();
        send_seq(13, 0, 1'b0, 1'b0);
        send_seq(20, 7, 1'b0, 1'b0);
        wait_done();
        frame_check("t4", 7, 2, 1, 1, 1);

        // 5: asynchronous reset with a window pending
        snap();
        send_seq(14, 0, 1'b0, 1'b0);
        chk("t5_pre_reset_valid", win_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_win_valid", win_valid, 1'b0);
        chk("t5_async_win", win, 36'h0);
        chk("t5_async_eol", win_eol, 1'b0);
        chk("t5_async_eof", win_eof, 1'b0);
        q.delete(); m_state = 0; m_row = 0; m_col = 0; exp_fd = 1'b0; exp_se = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        send_seq(20, 0, 1'b0, 1'b0);
        wait_done();
        frame_check("t5", 6, 2, 1, 1, 0);

        // 6: three random frames with random valid/ready
        snap(); sobel_on = 1'b0; rnd_ready = 1'b1;
        for (int f = 0; f < 3; f++) send_seq(20, 0, 1'b1, 1'b1);
        wait_done();
        frame_check("t6", 18, 6, 3, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
